fmt_sequencer: RTL and testbench
================================

# fmt_sequencer

Event-level scheduler for the data formatter. It counts events the DRS readout has deposited into the header (C) and channel (D) FIFOs, and launches one formatter pass per event only once every source FIFO holds data and the stream FIFO has room. It then checks each pass for completion, byte length and timeout. It sits between the trigger/readout control and the formatter, and supplies trigger dead-time backpressure.

## Interface
Parameters:
- PEND_W, 4: pending-event counter width; maximum pending events = 2^PEND_W − 1.
- TO_W, 20: timeout counter width; a pass times out after 2^TO_W − 1 cycles in RUN.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-low reset.
- ENABLE  input  1  when low, no new pass is launched; a pass in progress still completes.
- EVT_WRITTEN  input  1  one-cycle pulse: readout has finished writing one event into the C/D FIFOs.
- DRS_READDEPTH  input  13  samples per channel; sampled at launch.
- CFIFO_EMPTY  input  1  header FIFO empty.
- DFIFO_EMPTY  input  8  channel FIFO empty flags.
- SFIFO_PROGFULL  input  1  stream FIFO programmable-full.
- SFIFO_WREN  input  1  formatter write strobe into the stream FIFO; counted as bytes.
- FMT_DONE  input  1  one-cycle pulse from the formatter at the end of an event.
- FMT_START  output  1  one-cycle launch pulse.
- FMT_ABORT  output  1  one-cycle pulse telling the formatter to return to its idle state.
- TRIG_BUSY  output  1  high while pending == max; the trigger must be inhibited.
- PENDING  output  PEND_W  events written but not yet retired.
- EVT_CNT  output  32  events retired with correct length.
- DROP_CNT  output  16  EVT_WRITTEN pulses lost while pending == max; saturates.
- ERR_LEN  output  1  sticky: byte count mismatch at FMT_DONE.
- ERR_TO  output  1  sticky: timeout.
- ERR_CLR  input  1  clears ERR_LEN and ERR_TO.

## Operation
- Expected bytes per event: 20-bit value, 32 + 8×(4 + 4×DRS_READDEPTH), i.e. 32 + 32 + 32×DRS_READDEPTH. Computed combinationally and registered at launch (ARM→RUN).
- Pending counter:
  - increments on EVT_WRITTEN;
  - decrements on retire (DONE or ABORT state);
  - both in the same cycle leaves it unchanged;
  - EVT_WRITTEN at max with no retire that cycle leaves it unchanged and increments DROP_CNT.
- FSM states: IDLE, ARM, RUN, CHECK, ABORT.
- IDLE → ARM when ENABLE = 1 and PENDING ≠ 0.
- ARM → RUN when CFIFO_EMPTY = 0, DFIFO_EMPTY = 8'h00 and SFIFO_PROGFULL = 0. In the same cycle:
  - FMT_START is registered high for one cycle;
  - the byte counter and timeout counter clear;
  - expected length is latched.
- ARM stays in ARM while ENABLE is low.
- RUN: the byte counter increments on each SFIFO_WREN. The timeout counter increments every cycle.
  - FMT_DONE → CHECK.
  - Timeout reaching all-ones → ABORT.
  - FMT_DONE and timeout in the same cycle: FMT_DONE wins.
- CHECK waits one cycle so that the final SFIFO_WREN, which lags FMT_DONE by up to 2 cycles, is counted. It then compares the byte count with the expected length:
  - equal → EVT_CNT +1;
  - not equal → ERR_LEN set.
  - Either way the event retires → IDLE.
- ABORT: FMT_ABORT is high for one cycle, ERR_TO is set, the event retires → IDLE. EVT_CNT does not increment.
- ERR_CLR takes priority over a same-cycle error set only when no error event occurs that cycle; if an error occurs that cycle, set wins.
- Reset: FSM = IDLE; every output and counter = 0, including the FMT_START and FMT_ABORT registers.

## Timing
- All outputs are registered.
- FMT_START rises the cycle after the ARM launch condition is met.
- Minimum spacing between FMT_START pulses is 4 cycles.
- TRIG_BUSY updates one cycle after PENDING reaches or leaves max.
- Reset asserted mid-pass abandons the pass with no FMT_ABORT; the formatter is reset by the same RST.

## Configuration
- FMT_SEQ_TIMEOUT_EN defined: the timeout counter and ABORT state exist as described above.
- Not defined: the timeout counter and ABORT state are removed. RUN waits on FMT_DONE indefinitely, and FMT_ABORT and ERR_TO are tied to 0.

## Structure
- Shared package:
  - FSM state enum (3-bit);
  - header byte constant, 32;
  - per-channel overhead constant, 4;
  - bytes-per-sample constant, 4;
  - channel count, 8;
  - the expected-length function.
- One natural sub-module, fmt_seq_pending_ctr: the saturating up/down pending counter with the drop counter.

## Test plan
- DRS_READDEPTH = 1024, one EVT_WRITTEN, all FIFOs non-empty, 32832 SFIFO_WREN strobes then FMT_DONE → exactly one FMT_START; EVT_CNT = 1, PENDING = 0, no errors.
- Same as above but with 32831 strobes → ERR_LEN = 1, EVT_CNT = 0, PENDING = 0. Then ERR_CLR → ERR_LEN = 0.
- 16 EVT_WRITTEN pulses with PEND_W = 4 and no FMT_DONE → PENDING = 15, TRIG_BUSY = 1, DROP_CNT = 1.
- DFIFO_EMPTY = 8'h04 held for 100 cycles after EVT_WRITTEN → no FMT_START. Clearing it → FMT_START on the next cycle.
- With FMT_SEQ_TIMEOUT_EN and TO_W = 4, no FMT_DONE → FMT_ABORT 15 cycles after FMT_START; ERR_TO = 1, PENDING decremented.
- EVT_WRITTEN coincident with CHECK retire at PENDING = 3 → PENDING stays 3; RST low mid-RUN → all outputs 0 the next cycle.

Source files
------------

// File: rtl/fmt_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fmt_sequencer_pkg
// Shared definitions for the formatter event sequencer:
//   - seq_state_e   : sequencer FSM state encoding (3 bits)
//   - byte-length constants for one formatted event (header, per-channel
//     overhead, bytes per sample, channel count)
//   - expected_len(): expected byte count of one event for a given readout
//     depth, used to check each formatter pass.
// -----------------------------------------------------------------------------
package fmt_sequencer_pkg;

  // Width of the readout depth input and of byte-length quantities.
  localparam int unsigned DEPTH_W = 13;
  localparam int unsigned LEN_W   = 20;

  // Event layout: one header block, then per channel an overhead block plus
  // DEPTH samples of SAMPLE_BYTES each.
  localparam logic [LEN_W-1:0] HDR_BYTES    = 20'd32;
  localparam logic [LEN_W-1:0] CH_OVH_BYTES = 20'd4;
  localparam logic [LEN_W-1:0] SAMPLE_BYTES = 20'd4;
  localparam logic [LEN_W-1:0] NUM_CH       = 20'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_ABORT = 3'd4
  } seq_state_e;

  // Bytes the formatter is expected to write for one event. The largest
  // depth (8191) gives 262176 bytes, which fits comfortably in LEN_W bits.
  function automatic logic [LEN_W-1:0] expected_len(input logic [DEPTH_W-1:0] depth);
    logic [LEN_W-1:0] depth_ext;
    depth_ext = {{(LEN_W - DEPTH_W){1'b0}}, depth};
    return HDR_BYTES + NUM_CH * (CH_OVH_BYTES + SAMPLE_BYTES * depth_ext);
  endfunction

endpackage

// File: rtl/fmt_seq_pending_ctr.sv
// -----------------------------------------------------------------------------
// fmt_seq_pending_ctr
// Saturating up/down counter of events written by the readout but not yet
// retired by the sequencer, plus a saturating counter of events lost because
// the pending counter was already full.
//
// Ports:
//   clk_i        in   system clock
//   rst_ni       in   synchronous active-low reset
//   inc_i        in   one event written (EVT_WRITTEN)
//   dec_i        in   one event retired (checked or aborted)
//   pending_o    out  events outstanding, 0 .. 2^PEND_W-1
//   drop_cnt_o   out  events lost at full, saturates at 16'hFFFF
//   at_max_o     out  registered "pending is full", lags pending_o by a cycle
// -----------------------------------------------------------------------------
module fmt_seq_pending_ctr #(
  parameter int unsigned PEND_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [PEND_W-1:0] pending_o,
  output logic [15:0]       drop_cnt_o,
  output logic              at_max_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend_q, pend_d;
  logic [15:0]       drop_q, drop_d;
  logic              at_max_q;

  always_comb begin
    pend_d = pend_q;
    drop_d = drop_q;
    // A write and a retire in the same cycle cancel out, even at full.
    if (inc_i && !dec_i) begin
      if (pend_q == PEND_MAX) begin
        if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (dec_i && !inc_i) begin
      // A retire can only follow a launch, which needs pending != 0; the
      // guard just keeps the counter from wrapping if that ever breaks.
      if (pend_q != '0) begin
        pend_d = pend_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q   <= '0;
      drop_q   <= '0;
      at_max_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      // Derived from the registered count so it follows PENDING by one cycle.
      at_max_q <= (pend_q == PEND_MAX);
    end
  end

  assign pending_o  = pend_q;
  assign drop_cnt_o = drop_q;
  assign at_max_o   = at_max_q;

endmodule

// File: rtl/fmt_sequencer.sv
// -----------------------------------------------------------------------------
// fmt_sequencer
// Event-level scheduler for the data formatter. Counts events deposited into
// the header/channel FIFOs, launches one formatter pass per event once every
// source FIFO holds data and the stream FIFO has room, then checks each pass
// for completion, byte length and (optionally) timeout. Drives trigger
// dead-time backpressure when the pending counter is full.
//
// Build option: define FMT_SEQ_TIMEOUT_EN to include the pass timeout counter
// and the ABORT state. Without it RUN waits for FMT_DONE indefinitely and
// FMT_ABORT / ERR_TO are tied low.
//
// Parameters:
//   PEND_W  pending-event counter width (max pending = 2^PEND_W-1)
//   TO_W    timeout counter width (pass aborts after 2^TO_W-1 cycles in RUN)
//
// Ports:
//   CLK             in   system clock, rising edge
//   RST             in   synchronous active-low reset
//   ENABLE          in   allow new passes to launch
//   EVT_WRITTEN     in   pulse: one event written into the C/D FIFOs
//   DRS_READDEPTH   in   samples per channel, latched at launch
//   CFIFO_EMPTY     in   header FIFO empty
//   DFIFO_EMPTY     in   channel FIFO empty flags (8)
//   SFIFO_PROGFULL  in   stream FIFO programmable-full
//   SFIFO_WREN      in   formatter write strobe, one byte each
//   FMT_DONE        in   pulse: formatter finished the event
//   ERR_CLR         in   clear sticky error flags
//   FMT_START       out  pulse: launch a formatter pass
//   FMT_ABORT       out  pulse: send the formatter back to idle
//   TRIG_BUSY       out  pending counter full, inhibit trigger
//   PENDING         out  events written but not retired
//   EVT_CNT         out  events retired with correct length
//   DROP_CNT        out  events lost while full (saturating)
//   ERR_LEN         out  sticky length mismatch
//   ERR_TO          out  sticky pass timeout
// -----------------------------------------------------------------------------
module fmt_sequencer
  import fmt_sequencer_pkg::*;
#(
  parameter int unsigned PEND_W = 4,
  parameter int unsigned TO_W   = 20
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ENABLE,
  input  logic               EVT_WRITTEN,
  input  logic [DEPTH_W-1:0] DRS_READDEPTH,
  input  logic               CFIFO_EMPTY,
  input  logic [7:0]         DFIFO_EMPTY,
  input  logic               SFIFO_PROGFULL,
  input  logic               SFIFO_WREN,
  input  logic               FMT_DONE,
  input  logic               ERR_CLR,
  output logic               FMT_START,
  output logic               FMT_ABORT,
  output logic               TRIG_BUSY,
  output logic [PEND_W-1:0]  PENDING,
  output logic [31:0]        EVT_CNT,
  output logic [15:0]        DROP_CNT,
  output logic               ERR_LEN,
  output logic               ERR_TO
);

  seq_state_e        state_q, state_d;
  logic              start_q, start_d;
  logic [LEN_W-1:0]  byte_q, byte_d;
  logic [LEN_W-1:0]  exp_len_q, exp_len_d;
  logic [31:0]       evt_cnt_q, evt_cnt_d;
  logic              err_len_q, err_len_d;
  // High during the first CHECK cycle; the compare happens in the second so
  // that strobes lagging FMT_DONE by up to two cycles are still counted.
  logic              check_wait_q, check_wait_d;
  logic              len_err_set;
  logic              retire;
  logic              launch_ok;

`ifdef FMT_SEQ_TIMEOUT_EN
  logic [TO_W-1:0]   to_q, to_d;
  logic              abort_q, abort_d;
  logic              err_to_q, err_to_d;
  logic              to_err_set;
`else
  logic [TO_W-1:0]   to_unused;
  assign to_unused = '0;
`endif

  logic [PEND_W-1:0] pending;

  assign launch_ok = ENABLE && !CFIFO_EMPTY && (DFIFO_EMPTY == 8'h00) && !SFIFO_PROGFULL;

  // ---------------------------------------------------------------------------
  // Pending / drop counters
  // ---------------------------------------------------------------------------
  fmt_seq_pending_ctr #(
    .PEND_W (PEND_W)
  ) u_pending (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .inc_i      (EVT_WRITTEN),
    .dec_i      (retire),
    .pending_o  (pending),
    .drop_cnt_o (DROP_CNT),
    .at_max_o   (TRIG_BUSY)
  );

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    start_d      = 1'b0;
    byte_d       = byte_q;
    exp_len_d    = exp_len_q;
    evt_cnt_d    = evt_cnt_q;
    check_wait_d = check_wait_q;
    len_err_set  = 1'b0;
    retire       = 1'b0;
`ifdef FMT_SEQ_TIMEOUT_EN
    to_d         = to_q;
    abort_d      = 1'b0;
    to_err_set   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ENABLE && (pending != '0)) begin
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        // Launch only when every source FIFO has data and the sink has room.
        if (launch_ok) begin
          state_d   = ST_RUN;
          start_d   = 1'b1;
          byte_d    = '0;
          exp_len_d = expected_len(DRS_READDEPTH);
`ifdef FMT_SEQ_TIMEOUT_EN
          to_d      = '0;
`endif
        end
      end

      ST_RUN: begin
        if (SFIFO_WREN) begin
          byte_d = byte_q + 20'd1;
        end
`ifdef FMT_SEQ_TIMEOUT_EN
        to_d = to_q + 1'b1;
`endif
        // FMT_DONE takes precedence over a timeout in the same cycle.
        if (FMT_DONE) begin
          state_d      = ST_CHECK;
          check_wait_d = 1'b1;
        end
`ifdef FMT_SEQ_TIMEOUT_EN
        else if (to_d == '1) begin
          state_d = ST_ABORT;
          abort_d = 1'b1;
        end
`endif
      end

      ST_CHECK: begin
        if (SFIFO_WREN) begin
          byte_d = byte_q + 20'd1;
        end
        if (check_wait_q) begin
          check_wait_d = 1'b0;
        end else begin
          // Compare including this cycle's strobe (last possible lagging byte).
          retire  = 1'b1;
          state_d = ST_IDLE;
          if (byte_d == exp_len_q) begin
            evt_cnt_d = evt_cnt_q + 32'd1;
          end else begin
            len_err_set = 1'b1;
          end
        end
      end

`ifdef FMT_SEQ_TIMEOUT_EN
      ST_ABORT: begin
        retire     = 1'b1;
        to_err_set = 1'b1;
        state_d    = ST_IDLE;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Sticky errors: a same-cycle error set beats ERR_CLR.
    if (len_err_set) begin
      err_len_d = 1'b1;
    end else if (ERR_CLR) begin
      err_len_d = 1'b0;
    end else begin
      err_len_d = err_len_q;
    end

`ifdef FMT_SEQ_TIMEOUT_EN
    if (to_err_set) begin
      err_to_d = 1'b1;
    end else if (ERR_CLR) begin
      err_to_d = 1'b0;
    end else begin
      err_to_d = err_to_q;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      byte_q       <= '0;
      exp_len_q    <= '0;
      evt_cnt_q    <= '0;
      err_len_q    <= 1'b0;
      check_wait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      byte_q       <= byte_d;
      exp_len_q    <= exp_len_d;
      evt_cnt_q    <= evt_cnt_d;
      err_len_q    <= err_len_d;
      check_wait_q <= check_wait_d;
    end
  end

`ifdef FMT_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      to_q     <= '0;
      abort_q  <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      to_q     <= to_d;
      abort_q  <= abort_d;
      err_to_q <= err_to_d;
    end
  end

  // abort_q is set on entry to ABORT, so the pulse coincides with that state.
  assign FMT_ABORT = abort_q;
  assign ERR_TO    = err_to_q;
`else
  assign FMT_ABORT = 1'b0;
  assign ERR_TO    = 1'b0;
`endif

  assign FMT_START = start_q;
  assign PENDING   = pending;
  assign EVT_CNT   = evt_cnt_q;
  assign ERR_LEN   = err_len_q;

endmodule

// File: tb/tb_fmt_sequencer.sv
module tb_fmt_sequencer;

  localparam int PEND_W = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              ENABLE = 1'b0;
  logic              EVT_WRITTEN = 1'b0;
  logic [12:0]       DRS_READDEPTH = '0;
  logic              CFIFO_EMPTY = 1'b1;
  logic [7:0]        DFIFO_EMPTY = 8'hFF;
  logic              SFIFO_PROGFULL = 1'b0;
  logic              SFIFO_WREN = 1'b0;
  logic              FMT_DONE = 1'b0;
  logic              ERR_CLR = 1'b0;
  logic              FMT_START;
  logic              FMT_ABORT;
  logic              TRIG_BUSY;
  logic [PEND_W-1:0] PENDING;
  logic [31:0]       EVT_CNT;
  logic [15:0]       DROP_CNT;
  logic              ERR_LEN;
  logic              ERR_TO;

  always #5 CLK = ~CLK;

  fmt_sequencer #(.PEND_W(PEND_W), .TO_W(20)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .EVT_WRITTEN(EVT_WRITTEN),
    .DRS_READDEPTH(DRS_READDEPTH), .CFIFO_EMPTY(CFIFO_EMPTY),
    .DFIFO_EMPTY(DFIFO_EMPTY), .SFIFO_PROGFULL(SFIFO_PROGFULL),
    .SFIFO_WREN(SFIFO_WREN), .FMT_DONE(FMT_DONE), .ERR_CLR(ERR_CLR),
    .FMT_START(FMT_START), .FMT_ABORT(FMT_ABORT), .TRIG_BUSY(TRIG_BUSY),
    .PENDING(PENDING), .EVT_CNT(EVT_CNT), .DROP_CNT(DROP_CNT),
    .ERR_LEN(ERR_LEN), .ERR_TO(ERR_TO)
  );

`ifdef FMT_SEQ_TIMEOUT_EN
  logic              fa4, et4;
  logic [PEND_W-1:0] pend4;
  logic [31:0]       evt4;
  logic              fs4_unused, tb4_unused, el4_unused;
  logic [15:0]       drop4_unused;
  fmt_sequencer #(.PEND_W(PEND_W), .TO_W(4)) dut_to4 (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .EVT_WRITTEN(EVT_WRITTEN),
    .DRS_READDEPTH(DRS_READDEPTH), .CFIFO_EMPTY(CFIFO_EMPTY),
    .DFIFO_EMPTY(DFIFO_EMPTY), .SFIFO_PROGFULL(SFIFO_PROGFULL),
    .SFIFO_WREN(SFIFO_WREN), .FMT_DONE(FMT_DONE), .ERR_CLR(ERR_CLR),
    .FMT_START(fs4_unused), .FMT_ABORT(fa4), .TRIG_BUSY(tb4_unused),
    .PENDING(pend4), .EVT_CNT(evt4), .DROP_CNT(drop4_unused),
    .ERR_LEN(el4_unused), .ERR_TO(et4)
  );
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int abort_cnt = 0;

  always @(negedge CLK) begin
    if (FMT_START === 1'b1) start_cnt++;
    if (FMT_ABORT === 1'b1) abort_cnt++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Spec arithmetic: header + 8 channels * (overhead + 4 bytes per sample).
  function automatic int exp_bytes(input int depth);
    return 32 + 8 * (4 + 4 * depth);
  endfunction

  task automatic chk_zero(input string pfx);
    chk({pfx, "_fmt_start"}, FMT_START, 0);
    chk({pfx, "_fmt_abort"}, FMT_ABORT, 0);
    chk({pfx, "_trig_busy"}, TRIG_BUSY, 0);
    chk({pfx, "_pending"},   PENDING, 0);
    chk({pfx, "_evt_cnt"},   EVT_CNT, 0);
    chk({pfx, "_drop_cnt"},  DROP_CNT, 0);
    chk({pfx, "_err_len"},   ERR_LEN, 0);
    chk({pfx, "_err_to"},    ERR_TO, 0);
  endtask

  task automatic do_reset();
    RST = 1'b0; EVT_WRITTEN = 1'b0; SFIFO_WREN = 1'b0; FMT_DONE = 1'b0; ERR_CLR = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
  endtask

  task automatic pulse_evt();
    EVT_WRITTEN = 1'b1;
    tick();
    EVT_WRITTEN = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (FMT_START === 1'b1) found = 1'b1;
    end
    chk(tag, found, 1);
  endtask

  // n strobes total; the last 'post' come after FMT_DONE. The retire happens
  // on the second cycle after FMT_DONE; evt_last puts EVT_WRITTEN there.
  task automatic run_pass(input int n, input int post, input bit evt_last, input bit clr_first);
    for (int i = 0; i < n - post; i++) begin
      SFIFO_WREN = 1'b1;
      ERR_CLR    = clr_first && (i == 0);
      tick();
    end
    SFIFO_WREN = 1'b0; ERR_CLR = 1'b0; FMT_DONE = 1'b1;
    tick();
    FMT_DONE = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      SFIFO_WREN  = (k <= post);
      EVT_WRITTEN = evt_last && (k == 2);
      tick();
    end
    SFIFO_WREN = 1'b0; EVT_WRITTEN = 1'b0;
  endtask

  int s0, d, n, post, lat, pend_m, evt_m, errlen_m;
  bit clr;

  initial begin
    // ---- reset state
    repeat (2) tick();
    chk_zero("reset");
    RST = 1'b1;
    CFIFO_EMPTY = 1'b0; DFIFO_EMPTY = 8'h00; SFIFO_PROGFULL = 1'b0;

    // ---- full-size event, exact length (last two strobes after FMT_DONE)
    do_reset(); ENABLE = 1'b1; DRS_READDEPTH = 13'd1024;
    s0 = start_cnt;
    pulse_evt();
    wait_start("t1_start");
    run_pass(32832, 2, 1'b0, 1'b0);
    chk("t1_start_count", start_cnt - s0, 1);
    chk("t1_evt_cnt", EVT_CNT, 1);
    chk("t1_pending", PENDING, 0);
    chk("t1_err_len", ERR_LEN, 0);
    chk("t1_err_to", ERR_TO, 0);
    $display("txn t1: depth 1024, 32832 bytes, EVT_CNT=%0d ERR_LEN=%0d", EVT_CNT, ERR_LEN);

    // ---- one byte short
    do_reset(); ENABLE = 1'b1; DRS_READDEPTH = 13'd1024;
    pulse_evt();
    wait_start("t2_start");
    run_pass(32831, 0, 1'b0, 1'b0);
    chk("t2_err_len", ERR_LEN, 1);
    chk("t2_evt_cnt", EVT_CNT, 0);
    chk("t2_pending", PENDING, 0);
    ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
    chk("t2_err_clr", ERR_LEN, 0);
    $display("txn t2: depth 1024, 32831 bytes, ERR_LEN cleared=%0d", ERR_LEN);

    // ---- launch held off by one channel FIFO empty
    do_reset(); ENABLE = 1'b1; DRS_READDEPTH = 13'd0; DFIFO_EMPTY = 8'h04;
    s0 = start_cnt;
    pulse_evt();
    repeat (100) tick();
    chk("t3_no_start", start_cnt - s0, 0);
    DFIFO_EMPTY = 8'h00;
    tick();
    chk("t3_start_next", FMT_START, 1);
    run_pass(64, 1, 1'b0, 1'b0);
    chk("t3_evt_cnt", EVT_CNT, 1);
    $display("txn t3: dfifo hold-off, EVT_CNT=%0d", EVT_CNT);

    // ---- write coincident with retire
    do_reset(); ENABLE = 1'b0; DRS_READDEPTH = 13'd0;
    EVT_WRITTEN = 1'b1; repeat (3) tick(); EVT_WRITTEN = 1'b0;
    chk("t4_pending_pre", PENDING, 3);
    ENABLE = 1'b1;
    wait_start("t4_start");
    run_pass(64, 0, 1'b1, 1'b0);
    chk("t4_pending_post", PENDING, 3);
    chk("t4_evt_cnt", EVT_CNT, 1);
    $display("txn t4: retire+write, PENDING=%0d", PENDING);

    // ---- saturation and drop
    do_reset(); ENABLE = 1'b0;
    EVT_WRITTEN = 1'b1;
    repeat (15) tick();
    chk("t5_pending_15", PENDING, 15);
    chk("t5_busy_lag", TRIG_BUSY, 0);
    chk("t5_drop_0", DROP_CNT, 0);
    tick();
    EVT_WRITTEN = 1'b0;
    chk("t5_pending_sat", PENDING, 15);
    chk("t5_drop_1", DROP_CNT, 1);
    chk("t5_busy", TRIG_BUSY, 1);
    $display("txn t5: 16 writes, PENDING=%0d DROP_CNT=%0d TRIG_BUSY=%0d", PENDING, DROP_CNT, TRIG_BUSY);

    // ---- randomized passes against the reference model
    do_reset(); ENABLE = 1'b1;
    pend_m = 0; evt_m = 0; errlen_m = 0;
    for (int it = 0; it < 12; it++) begin
      d = $urandom_range(0, 15);
      DRS_READDEPTH = 13'(d);
      if (pend_m == 0 || (pend_m < 10 && $urandom_range(0, 2) == 0)) begin
        pulse_evt();
        pend_m++;
      end
      wait_start("rnd_start");
      DRS_READDEPTH = 13'($urandom_range(16, 8191));
      n = exp_bytes(d);
      case ($urandom_range(0, 2))
        1: n = n + $urandom_range(1, 3);
        2: n = n - $urandom_range(1, 3);
        default: ;
      endcase
      post = $urandom_range(0, 2);
      clr  = ($urandom_range(0, 3) == 0);
      run_pass(n, post, 1'b0, clr);
      if (clr) errlen_m = 0;
      if (n == exp_bytes(d)) evt_m++;
      else errlen_m = 1;
      pend_m--;
      chk("rnd_evt_cnt", EVT_CNT, evt_m);
      chk("rnd_err_len", ERR_LEN, errlen_m);
      chk("rnd_pending", PENDING, pend_m);
      $display("txn rnd %0d: depth %0d bytes %0d post %0d -> EVT_CNT=%0d ERR_LEN=%0d PENDING=%0d",
               it, d, n, post, EVT_CNT, ERR_LEN, PENDING);
    end

    // ---- reset in the middle of a pass
    DRS_READDEPTH = 13'd4;
    pulse_evt();
    wait_start("rst_mid_start");
    SFIFO_WREN = 1'b1; repeat (10) tick(); SFIFO_WREN = 1'b0;
    RST = 1'b0;
    tick();
    chk_zero("rst_mid");
    RST = 1'b1;
    $display("txn rst_mid: outputs cleared");

    chk("no_abort_main", abort_cnt, 0);

`ifdef FMT_SEQ_TIMEOUT_EN
    // ---- timeout with a 4-bit timeout counter
    do_reset(); ENABLE = 1'b1; DRS_READDEPTH = 13'd0;
    pulse_evt();
    wait_start("to_start");
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      tick();
      if (fa4 === 1'b1) lat = k;
    end
    chk("to_abort_latency", lat, 15);
    tick();
    chk("to_err_to", et4, 1);
    chk("to_pending", pend4, 0);
    chk("to_evt_cnt", evt4, 0);
    $display("txn timeout: abort after %0d cycles, ERR_TO=%0d", lat, et4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
